// File: rtl/mcp4822_pkg.sv
// Shared constants, per-channel DAC state type and code-to-millivolt scaling
// for the MCP4822 command-link receiver.
package mcp4822_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CH_SEL_BIT = 15;
    localparam int GA_N_BIT   = 13;
    localparam int SHDN_N_BIT = 12;

    typedef struct packed {
        logic [11:0] code;
        logic        gain2x;
        logic        active;
    } dac_ch_t;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } rx_state_t;

    // Vref is 2.048 V, so one LSB is 0.5 mV at 1x gain and 1 mV at 2x gain.
    function automatic logic [12:0] code_to_mv(input dac_ch_t ch);
        logic [12:0] mv;
        mv = '0;
        if (ch.active) begin
            mv = ch.gain2x ? {1'b0, ch.code} : {2'b00, ch.code[11:1]};
        end
        return mv;
    endfunction

endpackage

// File: rtl/mcp4822_spi_rx_if.sv
// SPI pins in, decoded DAC state out; with MCP4822_LDAC_EN the ldac_n pin is added.
interface mcp4822_spi_rx_if;

`ifdef MCP4822_LDAC_EN
    logic        ldac_n;
`endif
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;

    logic        frame_valid;
    logic        frame_err;
    logic [15:0] frame_word;
    logic [11:0] code_a;
    logic [11:0] code_b;
    logic        gain2x_a;
    logic        gain2x_b;
    logic        active_a;
    logic        active_b;
    logic [12:0] vout_mv_a;
    logic [12:0] vout_mv_b;
    logic [15:0] frame_count;

    modport slave (
`ifdef MCP4822_LDAC_EN
        input  ldac_n,
`endif
        input  spi_cs_n, spi_sck, spi_mosi,
        output frame_valid, frame_err, frame_word,
        output code_a, code_b, gain2x_a, gain2x_b, active_a, active_b,
        output vout_mv_a, vout_mv_b, frame_count
    );

    modport master (
`ifdef MCP4822_LDAC_EN
        output ldac_n,
`endif
        output spi_cs_n, spi_sck, spi_mosi,
        input  frame_valid, frame_err, frame_word,
        input  code_a, code_b, gain2x_a, gain2x_b, active_a, active_b,
        input  vout_mv_a, vout_mv_b, frame_count
    );

endinterface

// File: rtl/mcp4822_spi_rx_sync_edge_det.sv
// Multi-stage synchroniser for one asynchronous pin plus a history FF;
// rise/fall are combinational from the last stage versus history.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE_VAL}};
            hist_q <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~hist_q;
    assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/mcp4822_spi_rx.sv
// MCP4822 SPI receiver: oversampled mode-0 deserialiser, frame check and per-channel DAC state.
// Outputs update SYNC_STAGES+1 clk edges after CS rise is sampled; MCP4822_LDAC_EN adds LDAC gating.
module mcp4822_spi_rx
    import mcp4822_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mcp4822_spi_rx_if.slave        bus
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    logic cs_sync, cs_rise, cs_fall;
    logic sck_sync, sck_rise, sck_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(bus.spi_cs_n),
        .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d_i(bus.spi_sck),
        .sync_o(sck_sync), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(bus.spi_mosi),
        .sync_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

`ifdef MCP4822_LDAC_EN
    logic ldac_sync, ldac_rise, ldac_fall;
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ldac (
        .clk(clk), .rst_n(rst_n), .d_i(bus.ldac_n),
        .sync_o(ldac_sync), .rise_o(ldac_rise), .fall_o(ldac_fall)
    );
    logic unused_ldac;
    assign unused_ldac = &{1'b0, ldac_sync, ldac_rise};
    dac_ch_t in_a_q, in_a_d, in_b_q, in_b_d;
`endif

    logic unused_edges;
    assign unused_edges = &{1'b0, cs_sync, sck_sync, sck_fall, mosi_rise, mosi_fall};

    rx_state_t   state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [15:0] word_q, word_d;
    logic [15:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        commit;
    dac_ch_t     ch_new;
    dac_ch_t     out_a_q, out_a_d, out_b_q, out_b_d;
    logic [12:0] vout_a_q, vout_b_q;

    assign ch_new = '{code:   shreg_q[11:0],
                      gain2x: ~shreg_q[GA_N_BIT],
                      active: shreg_q[SHDN_N_BIT]};

    // CS rising edge wins over a coincident SCK rising edge.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        commit    = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_q == CNT_FULL) begin
                        commit  = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    shreg_d = {shreg_q[14:0], mosi_sync};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_d = commit ? shreg_q : word_q;
        cnt_d  = commit ? cnt_q + 16'd1 : cnt_q;
`ifdef MCP4822_LDAC_EN
        in_a_d  = (commit && !shreg_q[CH_SEL_BIT]) ? ch_new : in_a_q;
        in_b_d  = (commit &&  shreg_q[CH_SEL_BIT]) ? ch_new : in_b_q;
        // Transfer sees this cycle's commit so a coincident LDAC picks up the new word.
        out_a_d = ldac_fall ? in_a_d : out_a_q;
        out_b_d = ldac_fall ? in_b_d : out_b_q;
`else
        out_a_d = (commit && !shreg_q[CH_SEL_BIT]) ? ch_new : out_a_q;
        out_b_d = (commit &&  shreg_q[CH_SEL_BIT]) ? ch_new : out_b_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            vout_a_q  <= '0;
            vout_b_q  <= '0;
`ifdef MCP4822_LDAC_EN
            in_a_q    <= '0;
            in_b_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            vout_a_q  <= code_to_mv(out_a_d);
            vout_b_q  <= code_to_mv(out_b_d);
`ifdef MCP4822_LDAC_EN
            in_a_q    <= in_a_d;
            in_b_q    <= in_b_d;
`endif
        end
    end

    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign bus.frame_word  = word_q;
    assign bus.frame_count = cnt_q;
    assign bus.code_a      = out_a_q.code;
    assign bus.code_b      = out_b_q.code;
    assign bus.gain2x_a    = out_a_q.gain2x;
    assign bus.gain2x_b    = out_b_q.gain2x;
    assign bus.active_a    = out_a_q.active;
    assign bus.active_b    = out_b_q.active;
    assign bus.vout_mv_a   = vout_a_q;
    assign bus.vout_mv_b   = vout_b_q;

endmodule

// File: tb/tb_mcp4822_spi_rx.sv
// Drives SPI frames (directed then random lengths/words) into the receiver and
// compares every decoded output with a word-level reference model.
module tb_mcp4822_spi_rx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mcp4822_spi_rx_if bus();

    mcp4822_spi_rx #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending (input) and visible channel state, indexed 0=A, 1=B.
    int p_code[2], p_gain[2], p_act[2];
    int v_code[2], v_gain[2], v_act[2];
    int m_word, m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_mv(input int code, input int gain2x, input int act);
        if (act == 0) return 0;
        return gain2x ? code : code / 2;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            p_code[c] = 0; p_gain[c] = 0; p_act[c] = 0;
            v_code[c] = 0; v_gain[c] = 0; v_act[c] = 0;
        end
        m_word = 0;
        m_cnt  = 0;
    endtask

    task automatic model_transfer();
        for (int c = 0; c < 2; c++) begin
            v_code[c] = p_code[c]; v_gain[c] = p_gain[c]; v_act[c] = p_act[c];
        end
    endtask

    task automatic model_commit(input logic [15:0] w);
        int ch;
        ch = w[15] ? 1 : 0;
        p_code[ch] = int'(w) % 4096;
        p_gain[ch] = w[13] ? 0 : 1;
        p_act[ch]  = w[12] ? 1 : 0;
        m_word = int'(w);
        m_cnt  = (m_cnt + 1) % 65536;
`ifndef MCP4822_LDAC_EN
        model_transfer();
`endif
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".code_a"},   32'(bus.code_a),      32'(v_code[0]));
        chk({tag, ".code_b"},   32'(bus.code_b),      32'(v_code[1]));
        chk({tag, ".gain_a"},   32'(bus.gain2x_a),    32'(v_gain[0]));
        chk({tag, ".gain_b"},   32'(bus.gain2x_b),    32'(v_gain[1]));
        chk({tag, ".act_a"},    32'(bus.active_a),    32'(v_act[0]));
        chk({tag, ".act_b"},    32'(bus.active_b),    32'(v_act[1]));
        chk({tag, ".mv_a"},     32'(bus.vout_mv_a),   32'(ref_mv(v_code[0], v_gain[0], v_act[0])));
        chk({tag, ".mv_b"},     32'(bus.vout_mv_b),   32'(ref_mv(v_code[1], v_gain[1], v_act[1])));
        chk({tag, ".word"},     32'(bus.frame_word),  32'(m_word));
        chk({tag, ".count"},    32'(bus.frame_count), 32'(m_cnt));
    endtask

    // SCK = clk/16: 8 clk low, 8 clk high per bit, data set while SCK is low.
    task automatic shift_bit(input logic b);
        bus.spi_mosi = b;
        repeat (8) @(negedge clk);
        bus.spi_sck = 1'b1;
        repeat (8) @(negedge clk);
        bus.spi_sck = 1'b0;
    endtask

    task automatic watch_pulses(input int cycles, output int nv, output int ne, output int nboth);
        nv = 0; ne = 0; nboth = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.frame_valid === 1'b1) nv++;
            if (bus.frame_err === 1'b1) ne++;
            if (bus.frame_valid === 1'b1 && bus.frame_err === 1'b1) nboth++;
        end
    endtask

    task automatic send_frame(input string tag, input logic [15:0] w, input int nbits);
        logic [31:0] stream;
        int nv, ne, nboth;
        stream = {w, 16'($urandom)};
        bus.spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) shift_bit(stream[31-i]);
        repeat (8) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        watch_pulses(12, nv, ne, nboth);
        if (nbits == 16) model_commit(w);
        chk({tag, ".valid_pulses"}, 32'(nv), (nbits == 16) ? 32'd1 : 32'd0);
        chk({tag, ".err_pulses"},   32'(ne), (nbits == 16) ? 32'd0 : 32'd1);
        chk({tag, ".both_high"},    32'(nboth), 32'd0);
        check_outputs(tag);
    endtask

`ifdef MCP4822_LDAC_EN
    task automatic pulse_ldac(input string tag);
        bus.ldac_n = 1'b0;
        repeat (6) @(negedge clk);
        bus.ldac_n = 1'b1;
        repeat (6) @(negedge clk);
        model_transfer();
        check_outputs(tag);
    endtask
`endif

    initial begin
        int nv, ne, nboth;
        int nbits;
        logic [15:0] w;

        rst_n        = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
`ifdef MCP4822_LDAC_EN
        bus.ldac_n   = 1'b1;
`endif
        model_reset();
        repeat (4) @(negedge clk);
        chk("reset.valid", 32'(bus.frame_valid), 32'd0);
        chk("reset.err",   32'(bus.frame_err),   32'd0);
        check_outputs("reset");
        rst_n = 1'b1;
        watch_pulses(10, nv, ne, nboth);
        chk("reset_release.pulses", 32'(nv + ne), 32'd0);

`ifdef MCP4822_LDAC_EN
        send_frame("ldac_hold", 16'h3400, 16);
        pulse_ldac("ldac_xfer");
        chk("ldac_xfer.mv_a_512", 32'(bus.vout_mv_a), 32'd512);
`endif

        send_frame("a_1x_800", 16'h3800, 16);
`ifdef MCP4822_LDAC_EN
        pulse_ldac("a_1x_800_xfer");
`endif
        chk("a_1x_800.mv_a_1024", 32'(bus.vout_mv_a), 32'd1024);
        send_frame("b_2x_fff", 16'h9FFF, 16);
`ifdef MCP4822_LDAC_EN
        pulse_ldac("b_2x_fff_xfer");
`endif
        chk("b_2x_fff.mv_b_4095", 32'(bus.vout_mv_b), 32'd4095);
        send_frame("a_shdn", 16'h2ABC, 16);
`ifdef MCP4822_LDAC_EN
        pulse_ldac("a_shdn_xfer");
`endif
        send_frame("short15", 16'h1234, 15);
        send_frame("long17",  16'h5678, 17);

        // Abort a frame with reset after 8 bits; nothing may be reported for it.
        bus.spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) shift_bit(1'($urandom));
        rst_n        = 1'b0;
        bus.spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        check_outputs("rst_mid");
        rst_n = 1'b1;
        watch_pulses(12, nv, ne, nboth);
        chk("rst_mid.pulses", 32'(nv + ne), 32'd0);
        send_frame("after_rst", 16'h3123, 16);
`ifdef MCP4822_LDAC_EN
        pulse_ldac("after_rst_xfer");
`endif
        chk("after_rst.code_a_123", 32'(bus.code_a), 32'h123);

        for (int k = 0; k < 30; k++) begin
            w = 16'($urandom);
            nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 18)) : 16;
            send_frame($sformatf("rnd%0d_n%0d", k, nbits), w, nbits);
`ifdef MCP4822_LDAC_EN
            if ($urandom_range(0, 1) == 1) pulse_ldac($sformatf("rnd%0d_xfer", k));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcp4822_spi_rx.md
Name: mcp4822_spi_rx

Overview:
- SPI receiver that models the MCP4822 dual 12-bit DAC at the far end of the DAC command link.
- Oversamples spi_cs_n, spi_sck and spi_mosi in the clk domain and deserialises 16-bit frames.
- Decodes channel, gain and shutdown bits, and holds per-channel DAC state plus the output voltage in millivolts.
- Used as a bench/loopback monitor and an on-chip self-check of the sine generator's DAC stream.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on spi_cs_n/spi_sck/spi_mosi; minimum 2.
- FRAME_BITS, 16: bits per valid frame; fixed by the MCP4822 protocol.

Ports:
- clk  in  1  system clock; must be at least 4x the SCK frequency.
- rst_n  in  1  reset: asynchronous, active-low.
- spi_cs_n  in  1  chip select, active-low, asynchronous to clk.
- spi_sck  in  1  SPI clock, mode 0, idle low.
- spi_mosi  in  1  serial data, MSB first.
- frame_valid  out  1  one-cycle pulse when a correct frame is committed.
- frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than FRAME_BITS.
- frame_word  out  16  last committed raw word.
- code_a, code_b  out  12  per-channel DAC code.
- gain2x_a, gain2x_b  out  1  1 = 2x gain (GA_n bit was 0).
- active_a, active_b  out  1  0 = channel shut down (SHDN_n bit was 0).
- vout_mv_a, vout_mv_b  out  13  channel output in mV (Vref 2.048 V).
- frame_count  out  16  count of committed frames; wraps at 65535 -> 0.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, bit_cnt 0, shift register 0, synchroniser FFs load idle levels (cs_n=1, sck=0, mosi=0).
- Reset mid-frame discards the partial frame. No pulse is generated on reset release.
- Each input passes through SYNC_STAGES FFs, then one history FF. Edges are detected combinationally from the last sync stage versus the history FF.
- FSM states:
  - IDLE -> SHIFT on a cs_n falling edge: bit_cnt <= 0, shift register cleared.
  - SHIFT, on each sck rising edge: shreg <= {shreg[14:0], mosi_sync}; bit_cnt increments and saturates at 17 (5-bit counter).
  - SHIFT -> IDLE on a cs_n rising edge:
    - If bit_cnt == 16: commit and pulse frame_valid.
    - Otherwise: pulse frame_err; no register changes.
- SCK edges seen in IDLE are ignored. An sck rising edge in the same cycle as a cs_n rising edge is ignored; the CS edge has priority.
- Commit, decoding shreg as word w:
  - w[15] selects the channel (0 = A, 1 = B); w[14] is ignored.
  - The selected channel takes gain2x = ~w[13], active = w[12], code = w[11:0].
  - The other channel is unchanged.
  - frame_word <= w; frame_count increments.
- vout_mv is registered at commit and is 0 when inactive:
  - gain 1x: code >> 1 (truncate).
  - gain 2x: code (zero-extended to 13 bits).
- Latency: frame_valid, frame_err and all decoded outputs update on the (SYNC_STAGES+1)th clk edge after the first edge that samples spi_cs_n high. Decoded outputs change in the same cycle frame_valid is high.
- frame_valid and frame_err are never high together.

Optional Feature:
- MCP4822_LDAC_EN defined:
  - Adds input ldac_n (1 bit, asynchronous, synchronised like the SPI inputs).
  - A commit writes only internal input registers, and frame_valid still pulses.
  - Channel outputs (code/gain/active/vout) copy both input registers on each ldac_n falling edge (synchronised).
  - If a commit and an ldac_n falling edge occur in the same cycle, the transfer uses the newly committed value.
- MCP4822_LDAC_EN undefined: outputs update directly on commit, with no ldac_n port (models LDAC tied low).

Decomposition:
- Package mcp4822_pkg:
  - Field positions (CH_SEL_BIT=15, GA_N_BIT=13, SHDN_N_BIT=12).
  - FRAME_BITS.
  - typedef dac_ch_t struct {code[11:0], gain2x, active}.
  - Function code_to_mv(dac_ch_t) returning 13 bits.
- One sub-module, sync_edge_det: a SYNC_STAGES synchroniser plus rise/fall outputs, instantiated per input.

Test Plan:
- Frame 0x3800 (ch A, 1x, active, code 0x800), SCK = clk/16 -> one frame_valid; code_a=0x800, gain2x_a=0, active_a=1, vout_mv_a=1024, frame_count=1; channel B stays 0.
- Frame 0x9FFF (ch B, 2x, active, code 0xFFF) -> code_b=0xFFF, gain2x_b=1, vout_mv_b=4095; channel A unchanged.
- Frame 0x2ABC (ch A, SHDN_n=0) -> active_a=0, vout_mv_a=0, code_a=0xABC.
- 15-bit and 17-bit frames -> frame_err pulse each, no frame_valid, outputs and frame_count unchanged.
- rst_n pulsed low after 8 SCK rising edges, then a full 0x3123 frame -> no pulse for the aborted frame; code_a=0x123 after the second frame.
- MCP4822_LDAC_EN: frame 0x3400 -> code_a stays 0 until ldac_n falls, then 0x400 and vout_mv_a=512.
